// File: rtl/regfile_3r_if.sv
// Bus bundle for the three-read/one-write register file: write port,
// three read ports, clear request and sweep status.
interface regfile_3r_if #(
  parameter int Size      = 64,
  parameter int AddrWidth = 5
);
  logic                 clear_i;
  logic                 load;
  logic [AddrWidth-1:0] rd_addr;
  logic [Size-1:0]      rd_i;
  logic [AddrWidth-1:0] rs1_addr;
  logic [AddrWidth-1:0] rs2_addr;
  logic [AddrWidth-1:0] rs3_addr;
  logic [Size-1:0]      rs1_o;
  logic [Size-1:0]      rs2_o;
  logic [Size-1:0]      rs3_o;
  logic                 busy_o;

  // Requester side: drives writes, clears and read addresses.
  modport master (
    output clear_i, load, rd_addr, rd_i, rs1_addr, rs2_addr, rs3_addr,
    input  rs1_o, rs2_o, rs3_o, busy_o
  );

  // Register file side.
  modport slave (
    input  clear_i, load, rd_addr, rd_i, rs1_addr, rs2_addr, rs3_addr,
    output rs1_o, rs2_o, rs3_o, busy_o
  );
endinterface

// File: rtl/regfile_3r.sv
// Register file with three combinational read ports and one write port.
// After reset or a clear request the file is zeroed by a sweep that
// clears one entry per clock; user writes are dropped and all reads
// return zero while the sweep runs. Entry 0 can be hardwired to zero
// for an integer file, and writes can optionally be forwarded to reads.
module regfile_3r #(
  parameter int Size      = 64,
  parameter int AddrWidth = 5,
  parameter int ZeroReg   = 1,
  parameter int Bypass    = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_3r_if.slave  bus
);

  localparam int Depth = 2 ** AddrWidth;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] clr_cnt_q, clr_cnt_d;
  logic                 sweep_we;
  logic                 user_we;
  logic [Size-1:0]      entry_val [Depth];
  logic [AddrWidth-1:0] rs_addr [3];
  logic [Size-1:0]      rs_data [3];

  // Next-state logic: sweep progress, clear entry, and write qualification.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    sweep_we  = 1'b0;
    user_we   = 1'b0;
    unique case (state_q)
      CLEAR: begin
        // A clear request here is deliberately not looked at, so the
        // sweep never restarts or stretches.
        sweep_we  = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LastAddr) begin
          state_d = READY;
        end
      end
      READY: begin
        if (bus.clear_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else begin
          user_we = bus.load;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    // Reset blocks every storage write on its edge.
    if (reset) begin
      sweep_we = 1'b0;
      user_we  = 1'b0;
    end
  end

  // FSM and sweep counter registers; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign bus.busy_o = (state_q == CLEAR);

  // Storage: one register per entry so all three reads are combinational.
  genvar gi;
  generate
    for (gi = 0; gi < Depth; gi++) begin : g_entry
      if ((ZeroReg != 0) && (gi == 0)) begin : g_zero
        assign entry_val[gi] = '0;
      end else begin : g_reg
        logic [Size-1:0] entry_q, entry_d;

        // Sweep zeroing wins; otherwise take a qualified user write.
        always_comb begin
          entry_d = entry_q;
          if (sweep_we && (clr_cnt_q == AddrWidth'(gi))) begin
            entry_d = '0;
          end else if (user_we && (bus.rd_addr == AddrWidth'(gi))) begin
            entry_d = bus.rd_i;
          end
        end

        // Entry register; contents are zeroed by the sweep, not by reset.
        always_ff @(posedge clk) begin
          entry_q <= entry_d;
        end

        assign entry_val[gi] = entry_q;
      end
    end
  endgenerate

  assign rs_addr[0] = bus.rs1_addr;
  assign rs_addr[1] = bus.rs2_addr;
  assign rs_addr[2] = bus.rs3_addr;

  // Read ports: zero during a sweep, optional forwarding of the write data.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_read
      logic            fwd;
      logic [Size-1:0] data;

      // Forward only data that will really be stored on this edge; a write
      // to a hardwired-zero entry is never forwarded.
      always_comb begin
        fwd = (Bypass != 0) && user_we && (rs_addr[gi] == bus.rd_addr) &&
              !((ZeroReg != 0) && (bus.rd_addr == '0));
        data = entry_val[rs_addr[gi]];
        if (state_q == CLEAR) begin
          data = '0;
        end else if (fwd) begin
          data = bus.rd_i;
        end
      end

      assign rs_data[gi] = data;
    end
  endgenerate

  assign bus.rs1_o = rs_data[0];
  assign bus.rs2_o = rs_data[1];
  assign bus.rs3_o = rs_data[2];

endmodule
